// File: rtl/fetch_buffer_pkg.sv
// Shared fetch-path definitions: data widths, fetch FSM states and the queued entry layout.
package fetch_buffer_pkg;

  localparam int XLEN    = 64;
  localparam int INSTR_W = 32;
  localparam int ENTRY_W = XLEN + INSTR_W;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DROP  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Instructions are word aligned, so the two low address bits are always cleared.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch buffer bus: redirect input, instruction-memory handshake and the IF/ID output handshake.
interface fetch_buffer_if;
  import fetch_buffer_pkg::*;

  logic               redirect;
  logic [XLEN-1:0]    redirect_pc;
  logic               imem_req;
  logic [31:0]        imem_addr;
  logic               imem_ready;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               out_valid;
  logic [XLEN-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic               out_ready;

  modport master (
    input  redirect, redirect_pc, imem_ready, imem_rvalid, imem_rdata, out_ready,
    output imem_req, imem_addr, out_valid, out_pc, out_instr
  );

  modport slave (
    output redirect, redirect_pc, imem_ready, imem_rvalid, imem_rdata, out_ready,
    input  imem_req, imem_addr, out_valid, out_pc, out_instr
  );

endinterface

// File: rtl/fetch_buffer_sync_fifo.sv
// Synchronous FIFO with flush; the head entry is read straight from the storage registers.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Qualify push/pop so the FIFO can never over- or underflow on its own.
  always_comb begin
    push_ok_s = 1'b0;
    pop_ok_s  = 1'b0;
    if (rst || flush) begin
      push_ok_s = 1'b0;
      pop_ok_s  = 1'b0;
    end else begin
      pop_ok_s  = pop && (count_r != {CW{1'b0}});
      push_ok_s = push && ((count_r != CNT_FULL) || pop_ok_s);
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign count     = count_r;

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: issues one imem request at a time and queues {pc, instr} for IF/ID.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
  input logic            clk,
  input logic            rst,
  fetch_buffer_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  fetch_state_t    state_r;
  logic [XLEN-1:0] fetch_pc_r;
  logic [XLEN-1:0] req_pc_r;

  logic [CW-1:0]   count_s;
  fetch_entry_t    head_s;
  fetch_entry_t    push_entry_s;
  logic            issue_s;
  logic            accept_s;
  logic            push_s;
  logic            pop_s;
  logic            out_valid_s;
  logic            outstanding_s;

  // Issue is only possible with nothing outstanding, so count < DEPTH keeps count + outstanding <= DEPTH.
  always_comb begin
    issue_s       = 1'b0;
    outstanding_s = (state_r == ST_WAIT) || (state_r == ST_DROP);
    if (!rst && !bus.redirect && (state_r == ST_FETCH) && (count_s < CNT_FULL)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  assign accept_s     = issue_s && bus.imem_ready;
  assign push_s       = !rst && !bus.redirect && (state_r == ST_WAIT) && bus.imem_rvalid;
  assign out_valid_s  = !rst && (count_s != {CW{1'b0}});
  assign pop_s        = out_valid_s && bus.out_ready && !bus.redirect;
  assign push_entry_s = '{pc: req_pc_r, instr: bus.imem_rdata};

  // Fetch FSM; redirect overrides everything and drops a response still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_FETCH;
      fetch_pc_r <= RESET_PC;
      req_pc_r   <= {XLEN{1'b0}};
    end else if (bus.redirect) begin
      fetch_pc_r <= align_pc(bus.redirect_pc);
      state_r    <= (outstanding_s && !bus.imem_rvalid) ? ST_DROP : ST_FETCH;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (accept_s) begin
            req_pc_r   <= fetch_pc_r;
            fetch_pc_r <= fetch_pc_r + 64'd4;
            state_r    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.imem_rvalid) begin
            state_r <= ST_FETCH;
          end
        end
        ST_DROP: begin
          if (bus.imem_rvalid) begin
            state_r <= ST_FETCH;
          end
        end
        default: state_r <= ST_FETCH;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .flush     (bus.redirect),
    .head_data (head_s),
    .count     (count_s)
  );

  assign bus.imem_req  = issue_s;
  assign bus.imem_addr = fetch_pc_r[31:0];
  assign bus.out_valid = out_valid_s;
  assign bus.out_pc    = head_s.pc;
  assign bus.out_instr = head_s.instr;

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4, entry count of the instruction queue (power of two, >=2).
REQ-002 Parameter RESET_PC, default 64'h0, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 redirect  input  1  discard all queued/in-flight fetches and restart at redirect_pc (misprediction or predicted-taken).
REQ-006 redirect_pc  input  64  new fetch address; bits [1:0] forced to 0.
REQ-007 imem_req  output  1  fetch request valid.
REQ-008 imem_addr  output  32  fetch address, fetch_pc[31:0].
REQ-009 imem_ready  input  1  memory accepts request this cycle (req && ready = accept).
REQ-010 imem_rvalid  input  1  instruction response valid.
REQ-011 imem_rdata  input  32  instruction word.
REQ-012 out_valid  output  1  head entry valid toward IF/ID.
REQ-013 out_pc  output  64  PC of head entry.
REQ-014 out_instr  output  32  instruction of head entry.
REQ-015 out_ready  input  1  consumer takes head (pop = out_valid && out_ready).

Function
REQ-016 At most one outstanding imem request; responses arrive in order, >=1 cycle after acceptance.
REQ-017 FSM states: FETCH (may issue), WAIT (one request outstanding), DROP (outstanding response to be discarded).
REQ-018 FETCH: imem_req=1 iff count + 0 < DEPTH; on accept latch req_pc=fetch_pc, fetch_pc += 4 (mod 2^64), go WAIT.
REQ-019 WAIT: on imem_rvalid push {req_pc, imem_rdata}, go FETCH; imem_req=0 in WAIT.
REQ-020 DROP: imem_req=0; on imem_rvalid discard data, go FETCH.
REQ-021 Redirect (any state): flush queue (count=0), fetch_pc=redirect_pc&~3; next state DROP if request outstanding and no imem_rvalid this cycle, else FETCH; response arriving same cycle as redirect discarded; no request issued in redirect cycle.
REQ-022 Redirect has priority over push and pop in the same cycle.
REQ-023 Push and pop in same cycle permitted at any count; count unchanged.
REQ-024 Issue gated so count + outstanding <= DEPTH; push never occurs when full; pop when empty impossible (out_valid=0).
REQ-025 out_valid = (count != 0); out_pc/out_instr driven from head register, stable while out_valid && !out_ready.
REQ-026 No bypass: pushed entry visible on outputs the cycle after imem_rvalid; minimum request-to-out_valid latency 2 cycles.
REQ-027 Pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.

Reset
REQ-028 While rst=1: imem_req=0, out_valid=0, count=0, pointers=0, state FETCH, fetch_pc=RESET_PC.
REQ-029 Instruction memory shares rst; no response is pending after reset, reset mid-WAIT abandons the request.
REQ-030 First request asserted in cycle after rst deasserts, with imem_addr=RESET_PC[31:0].

Structure
REQ-031 Shared definitions file holds XLEN=64, INSTR_W=32, fetch state enum, fetch entry struct {pc, instr}.
REQ-032 Queue storage implemented as sub-module sync_fifo (parameterised width/depth, push/pop/flush, count output).
REQ-033 FSM, fetch_pc and issue gating reside in fetch_buffer.

Verification
REQ-034 Reset, imem_ready=1, 1-cycle response, out_ready=1 -> addrs 0,4,8 in consecutive issue; out_pc 0,4,8 in order, first out_valid 2 cycles after first request.
REQ-035 out_ready=0 with DEPTH=4 -> exactly 4 entries fill, imem_req stays 0; out_ready=1 -> entries drain PC 0,4,8,12, fetching resumes at 16.
REQ-036 Redirect to 0x100 while WAIT, response 2 cycles later -> response discarded (DROP), next request addr 0x100, first out_pc 0x100.
REQ-037 Redirect to 0x203 in same cycle as imem_rvalid and pop -> data discarded, queue empty next cycle, next imem_addr 0x200.
REQ-038 imem_ready held 0 for 5 cycles -> imem_req and imem_addr 0x0 held stable, no push; accepted on ready.
REQ-039 rst asserted with 3 entries queued -> out_valid=0 next cycle, refetch from RESET_PC.
